cross_power_conj_mult: RTL and testbench
========================================

// Module: cross_power_conj_mult
// PURPOSE
// - Downstream stage of the 128x128 2D FFT in the phase-correlation datapath.
// - Consumes two column-FFT output streams: spectrum A (reference image) and spectrum B (shifted image).
// - Forms the cross-power product A * conj(B) per bin, then rounds, scales and saturates it to 16-bit complex.
// - Emits it as an AXI-stream for the downstream normalisation / inverse-FFT stage, with row framing (tlast) and a frame-done pulse.
// PARAMETERS
// - DW     16   component width (re/im, signed two's complement)
// - N      128  bins per row; m_tlast asserted on every Nth output
// - ROWS   128  rows per frame; frame_done after N*ROWS outputs
// - SHIFT  15   arithmetic right shift applied to the product sums; legal range 1..2*DW-1
// PORTS
// - clk         in   1     sole clock, rising edge
// - rst_n       in   1     reset, asynchronous, active-low
// - s_a_tdata   in   2*DW  spectrum A: [2DW-1:DW]=imag, [DW-1:0]=real (FFT core layout)
// - s_a_tvalid  in   1     A sample valid
// - s_a_tready  out  1     A sample accepted
// - s_b_tdata   in   2*DW  spectrum B, same layout
// - s_b_tvalid  in   1     B sample valid
// - s_b_tready  out  1     B sample accepted
// - m_tdata     out  2*DW  A*conj(B): [2DW-1:DW]=imag, [DW-1:0]=real
// - m_tvalid    out  1     output valid
// - m_tready    in   1     downstream ready
// - m_tlast     out  1     last bin of a row (col == N-1), qualified by m_tvalid
// - frame_done  out  1     one-cycle pulse after the last sample of the frame is transferred
// - ovf         out  1     sticky: set when any output component saturated
// - ovf_clr     in   1     synchronous clear of ovf; takes priority over a same-cycle set
// BEHAVIOUR
// - Reset (async, active-low): every output 0 (tdata, tvalid, tready, tlast, frame_done, ovf); all pipeline valids and col/row counters 0.
// - Reset mid-frame: the partial frame is discarded; the first output after reset is col 0, row 0.
// - stall = m_tvalid & ~m_tready. All pipeline stages share one enable: en = ~stall.
// - Join handshake:
//   - s_a_tready = s_b_tvalid & en; s_b_tready = s_a_tvalid & en.
//   - A pair is accepted only when both valids are high and en is high.
//   - A lone valid waits; its tdata must be held by the source (AXI rule).
// - Pipeline: 3 stages, accept -> m_tvalid 3 clk later when unstalled; 1 pair/clk sustained.
//   - S1: register ar*br, ai*bi, ai*br, ar*bi (signed 2DW bits each).
//   - S2: re_s = ar*br + ai*bi; im_s = ai*br - ar*bi (signed 2DW+1 bits).
//   - S3: x' = (x_s + 2^(SHIFT-1)) >>> SHIFT. Saturate to [-2^(DW-1), 2^(DW-1)-1]. Set ovf if either component clipped.
// - Stall: while stall is high, m_tdata, m_tlast and m_tvalid hold; no input is accepted; no bubble is lost or duplicated.
// - Counters advance on output transfer (m_tvalid & m_tready):
//   - col: 0..N-1, wraps to 0.
//   - row: increments on col wrap; row 0..ROWS-1, wraps to 0.
// - m_tlast = (col == N-1).
// - frame_done = 1 for the single clk after the transfer with col == N-1 and row == ROWS-1; the counters wrap at the same time.
// - Input tlast is not used; framing comes only from the counters.
// TESTING
// - A=(re 16384, im 0), B=(16384, 0), SHIFT=15 -> m_tdata re=8192, im=0; m_tvalid 3 clk after accept.
// - A=(0, 16384), B=(16384, 0) -> (0, +8192). A=(16384, 0), B=(0, 16384) -> (0, -8192) (conjugate on B).
// - A=B=(-32768, -32768) -> re saturates to 32767, im=0, ovf=1. ovf_clr for 1 clk -> ovf=0.
// - m_tready low for 5 clk mid-stream -> m_tdata stable, both s_*_tready=0; output sequence equals golden model with no loss or duplication.
// - B valid 4 clk after A, with random valid gaps on both inputs -> no transfer until both are valid; pairing of A[k] with B[k] preserved.
// - 16384 pairs with a random m_tready pattern -> 128 m_tlast pulses and 1 frame_done.
// - rst_n low at output 300 -> outputs 0; next frame starts at col 0 / row 0.

Source files
------------

// File: rtl/cross_power_conj_mult.sv
// Cross-power stage of the phase-correlation datapath: joins spectra A and B,
// forms A*conj(B) per bin, rounds/scales/saturates it, and frames the output stream.
module cross_power_conj_mult #(
  parameter int DW    = 16,
  parameter int N     = 128,
  parameter int ROWS  = 128,
  parameter int SHIFT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2*DW-1:0] s_a_tdata,
  input  logic          s_a_tvalid,
  output logic          s_a_tready,
  input  logic [2*DW-1:0] s_b_tdata,
  input  logic          s_b_tvalid,
  output logic          s_b_tready,
  output logic [2*DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          frame_done,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int PW  = 2 * DW;
  localparam int SW  = 2 * DW + 1;
  localparam int RW  = 2 * DW + 2;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [RW-1:0] RND  = RW'(64'd1 << (SHIFT - 1));
  localparam logic signed [RW-1:0] MAXV = RW'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  // Returns {clipped, value}: round half up, arithmetic shift, clamp to DW bits.
  function automatic logic [DW:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [RW-1:0] r;
    r = (RW'(x) + RND) >>> SHIFT;
    if (r > MAXV)      return {1'b1, MAXV[DW-1:0]};
    else if (r < MINV) return {1'b1, MINV[DW-1:0]};
    else               return {1'b0, r[DW-1:0]};
  endfunction

  logic signed [DW-1:0] ar, ai, br, bi;
  logic stall, en, accept, xfer, col_last, row_last;
  logic [DW:0] re_rs, im_rs;

  logic                 v1_d, v1_q, v2_d, v2_q;
  logic signed [PW-1:0] p_rr_d, p_rr_q, p_ii_d, p_ii_q, p_ir_d, p_ir_q, p_ri_d, p_ri_q;
  logic signed [SW-1:0] re_s_d, re_s_q, im_s_d, im_s_q;
  logic                 m_tvalid_d, m_tvalid_q;
  logic [PW-1:0]        m_tdata_d, m_tdata_q;
  logic                 ovf_d, ovf_q, frame_done_d, frame_done_q;
  logic [CW-1:0]        col_d, col_q;
  logic [RBW-1:0]       row_d, row_q;

  assign ar = s_a_tdata[DW-1:0];
  assign ai = s_a_tdata[2*DW-1:DW];
  assign br = s_b_tdata[DW-1:0];
  assign bi = s_b_tdata[2*DW-1:DW];

  assign stall    = m_tvalid_q & ~m_tready;
  assign en       = ~stall;
  assign xfer     = m_tvalid_q & m_tready;
  assign col_last = (col_q == CW'(N - 1));
  assign row_last = (row_q == RBW'(ROWS - 1));

  // Readies are gated by rst_n so nothing is acknowledged while held in reset.
  assign s_a_tready = rst_n & s_b_tvalid & en;
  assign s_b_tready = rst_n & s_a_tvalid & en;
  assign accept     = rst_n & s_a_tvalid & s_b_tvalid & en;

  assign re_rs = round_sat(re_s_q);
  assign im_rs = round_sat(im_s_q);

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tvalid_q & col_last;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;

  always_comb begin
    v1_d = v1_q;  v2_d = v2_q;  m_tvalid_d = m_tvalid_q;
    p_rr_d = p_rr_q;  p_ii_d = p_ii_q;  p_ir_d = p_ir_q;  p_ri_d = p_ri_q;
    re_s_d = re_s_q;  im_s_d = im_s_q;
    m_tdata_d = m_tdata_q;
    col_d = col_q;  row_d = row_q;
    if (en) begin
      v1_d       = accept;
      v2_d       = v1_q;
      m_tvalid_d = v2_q;
    end
    if (accept) begin
      p_rr_d = PW'(ar) * PW'(br);
      p_ii_d = PW'(ai) * PW'(bi);
      p_ir_d = PW'(ai) * PW'(br);
      p_ri_d = PW'(ar) * PW'(bi);
    end
    if (en && v1_q) begin
      re_s_d = SW'(p_rr_q) + SW'(p_ii_q);
      im_s_d = SW'(p_ir_q) - SW'(p_ri_q);
    end
    if (en && v2_q) m_tdata_d = {im_rs[DW-1:0], re_rs[DW-1:0]};
    // Clear wins over a set landing in the same cycle.
    ovf_d = ovf_q | (en & v2_q & (re_rs[DW] | im_rs[DW]));
    if (ovf_clr) ovf_d = 1'b0;
    if (xfer) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RBW'(1);
    end
    frame_done_d = xfer & col_last & row_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;  v2_q <= 1'b0;  m_tvalid_q <= 1'b0;
      p_rr_q <= '0;  p_ii_q <= '0;  p_ir_q <= '0;  p_ri_q <= '0;
      re_s_q <= '0;  im_s_q <= '0;
      m_tdata_q <= '0;
      ovf_q <= 1'b0;  frame_done_q <= 1'b0;
      col_q <= '0;  row_q <= '0;
    end else begin
      v1_q <= v1_d;  v2_q <= v2_d;  m_tvalid_q <= m_tvalid_d;
      p_rr_q <= p_rr_d;  p_ii_q <= p_ii_d;  p_ir_q <= p_ir_d;  p_ri_q <= p_ri_d;
      re_s_q <= re_s_d;  im_s_q <= im_s_d;
      m_tdata_q <= m_tdata_d;
      ovf_q <= ovf_d;  frame_done_q <= frame_done_d;
      col_q <= col_d;  row_q <= row_d;
    end
  end

endmodule

// File: tb/tb_cross_power_conj_mult.sv
// Bench for cross_power_conj_mult: constant vector table, hand sequences for
// handshake corners, and randomized streams scored against a real-arithmetic model.
module tb_cross_power_conj_mult;

  localparam int DW = 16, N = 128, ROWS = 128, SHIFT = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] s_a_tdata, s_b_tdata, m_tdata;
  logic s_a_tvalid, s_a_tready, s_b_tvalid, s_b_tready;
  logic m_tvalid, m_tready, m_tlast, frame_done, ovf, ovf_clr;

  always #5 clk = ~clk;

  cross_power_conj_mult #(.DW(DW), .N(N), .ROWS(ROWS), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
    .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .frame_done(frame_done), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic signed [15:0] er, ei;
    logic               eovf;
  } vec_t;

  int checks = 0, failures = 0;
  logic [31:0] a_src[$], b_src[$];
  logic [32:0] exp_q[$];
  int a_p = 100, b_p = 100, rdy_p = 100;
  int col_m = 0, row_m = 0;
  bit fd_exp = 0, hold_v = 0, a_acc_prev = 0, b_acc_prev = 0, clip_seen = 0;
  logic [31:0] hold_d;
  int tcount = 0, acc_tick = -1, xfer_tick = -1;
  int out_cnt = 0, tlast_cnt = 0, fd_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference: exact real arithmetic, round half up, then clamp to 16-bit signed.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    int ar, ai, br, bi;
    real re, im, scale;
    longint r, i;
    bit c;
    ar = $signed(a[15:0]);  ai = $signed(a[31:16]);
    br = $signed(b[15:0]);  bi = $signed(b[31:16]);
    re = real'(ar) * real'(br) + real'(ai) * real'(bi);
    im = real'(ai) * real'(br) - real'(ar) * real'(bi);
    scale = 2.0 ** SHIFT;
    r = longint'($floor(re / scale + 0.5));
    i = longint'($floor(im / scale + 0.5));
    c = 0;
    if (r > 32767)  begin r = 32767;  c = 1; end
    if (r < -32768) begin r = -32768; c = 1; end
    if (i > 32767)  begin i = 32767;  c = 1; end
    if (i < -32768) begin i = -32768; c = 1; end
    return {c, i[15:0], r[15:0]};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] == 4'd0) return r[4] ? 16'h8000 : 16'h7fff;
    return r[31:16];
  endfunction

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    a_src.push_back(a);
    b_src.push_back(b);
    exp_q.push_back(model(a, b));
  endtask

  // One clock: drive at negedge, sample 1 ns later, score, then step past posedge.
  task automatic applyStimulus();
    bit a_acc, b_acc;
    logic [32:0] e;
    @(negedge clk);
    tcount++;
    if (a_acc_prev && a_src.size() > 0) begin void'(a_src.pop_front()); s_a_tvalid = 1'b0; end
    if (b_acc_prev && b_src.size() > 0) begin void'(b_src.pop_front()); s_b_tvalid = 1'b0; end
    if (!s_a_tvalid && a_src.size() > 0 && $urandom_range(99) < a_p) begin
      s_a_tvalid = 1'b1;  s_a_tdata = a_src[0];
    end
    if (!s_b_tvalid && b_src.size() > 0 && $urandom_range(99) < b_p) begin
      s_b_tvalid = 1'b1;  s_b_tdata = b_src[0];
    end
    m_tready = ($urandom_range(99) < rdy_p);
    #1;
    checkOutput("frame_done", frame_done, fd_exp);
    if (hold_v) begin
      checkOutput("stall_hold_valid", m_tvalid, 1);
      checkOutput("stall_hold_data", m_tdata, hold_d);
    end
    if (m_tvalid && !m_tready) begin
      checkOutput("stall_a_ready", s_a_tready, 0);
      checkOutput("stall_b_ready", s_b_tready, 0);
    end
    a_acc = s_a_tvalid & s_a_tready;
    b_acc = s_b_tvalid & s_b_tready;
    checkOutput("join_pairing", a_acc, b_acc);
    if (a_acc) acc_tick = tcount;
    fd_exp = 0;
    if (m_tvalid && m_tready) begin
      xfer_tick = tcount;
      out_cnt++;
      if (exp_q.size() == 0) failNow("unexpected_output");
      else begin
        e = exp_q.pop_front();
        checkOutput("tdata", m_tdata, e[31:0]);
        clip_seen |= e[32];
      end
      checkOutput("tlast", m_tlast, col_m == N - 1);
      tlast_cnt += int'(m_tlast);
      fd_exp = (col_m == N - 1) && (row_m == ROWS - 1);
      if (col_m == N - 1) begin
        col_m = 0;
        row_m = (row_m == ROWS - 1) ? 0 : row_m + 1;
      end else col_m++;
    end else if (!m_tvalid) checkOutput("tlast_unqualified", m_tlast, 0);
    hold_v = m_tvalid & ~m_tready;
    hold_d = m_tdata;
    fd_cnt += int'(frame_done);
    a_acc_prev = a_acc;
    b_acc_prev = b_acc;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((a_src.size() > 0 || b_src.size() > 0 || exp_q.size() > 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    if (n >= budget) failNow("drain_timeout");
    repeat (2) applyStimulus();
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    applyStimulus();
    ovf_clr = 1'b0;
    checkOutput("ovf_after_clr", ovf, 0);
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_tdata", m_tdata, 0);
    checkOutput("rst_tvalid", m_tvalid, 0);
    checkOutput("rst_tlast", m_tlast, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_a_ready", s_a_tready, 0);
    checkOutput("rst_b_ready", s_b_tready, 0);
  endtask

  initial begin
    vec_t vecs[$];
    int start, n, tl0, fd0;
    logic [31:0] a, b;

    s_a_tdata = '0;  s_b_tdata = '0;  s_a_tvalid = 0;  s_b_tvalid = 0;
    m_tready = 0;  ovf_clr = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    s_a_tvalid = 1;  s_b_tvalid = 1;
    #2;
    check_reset_outputs();
    s_a_tvalid = 0;  s_b_tvalid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs.push_back('{ar:16384,  ai:0,      br:16384,  bi:0,      er:8192,   ei:0,      eovf:0});
    vecs.push_back('{ar:0,      ai:16384,  br:16384,  bi:0,      er:0,      ei:8192,   eovf:0});
    vecs.push_back('{ar:16384,  ai:0,      br:0,      bi:16384,  er:0,      ei:-8192,  eovf:0});
    vecs.push_back('{ar:-32768, ai:-32768, br:-32768, bi:-32768, er:32767,  ei:0,      eovf:1});
    vecs.push_back('{ar:-32768, ai:-32768, br:-32768, bi:32767,  er:1,      ei:32767,  eovf:1});
    vecs.push_back('{ar:-32768, ai:-32768, br:32767,  bi:-32768, er:1,      ei:-32768, eovf:1});
    vecs.push_back('{ar:32767,  ai:0,      br:32767,  bi:0,      er:32766,  ei:0,      eovf:0});
    vecs.push_back('{ar:-32768, ai:0,      br:32767,  bi:0,      er:-32767, ei:0,      eovf:0});
    vecs.push_back('{ar:100,    ai:-200,   br:300,    bi:50,     er:1,      ei:-2,     eovf:0});
    vecs.push_back('{ar:-128,   ai:0,      br:128,    bi:0,      er:0,      ei:0,      eovf:0});
    vecs.push_back('{ar:128,    ai:0,      br:128,    bi:0,      er:1,      ei:0,      eovf:0});

    for (int i = 0; i < vecs.size(); i++) begin
      clear_ovf();
      a_src.push_back({vecs[i].ai, vecs[i].ar});
      b_src.push_back({vecs[i].bi, vecs[i].br});
      exp_q.push_back({vecs[i].eovf, vecs[i].ei, vecs[i].er});
      acc_tick = -1;
      xfer_tick = -1;
      drain(50);
      checkOutput("latency", 32'(xfer_tick - acc_tick), 3);
      checkOutput("ovf", ovf, vecs[i].eovf);
    end
    clear_ovf();

    // Clear coinciding with the clipped sample reaching the output stage.
    a = {16'h8000, 16'h8000};
    push_pair(a, a);
    acc_tick = -1;
    n = 0;
    while (acc_tick < 0 && n < 20) begin applyStimulus(); n++; end
    if (acc_tick < 0) failNow("accept_timeout");
    applyStimulus();
    ovf_clr = 1'b1;
    applyStimulus();
    ovf_clr = 1'b0;
    checkOutput("clr_priority_valid", m_tvalid, 1);
    checkOutput("clr_priority_ovf", ovf, 0);
    drain(50);

    // Five-cycle downstream stall mid-stream.
    for (int i = 0; i < 20; i++) push_pair({rnd16(), rnd16()}, {rnd16(), rnd16()});
    repeat (8) applyStimulus();
    rdy_p = 0;
    repeat (5) applyStimulus();
    rdy_p = 100;
    drain(200);

    // B arrives four cycles after A, then both sides gap randomly.
    for (int i = 0; i < 12; i++) push_pair({rnd16(), rnd16()}, {rnd16(), rnd16()});
    b_p = 0;
    repeat (4) begin
      applyStimulus();
      checkOutput("late_b_a_ready", s_a_tready, 0);
      checkOutput("late_b_b_ready", s_b_tready, 1);
      checkOutput("late_b_no_output", m_tvalid, 0);
    end
    a_p = 60;  b_p = 60;  rdy_p = 80;
    drain(500);

    // Reset at output 300 of a fresh stream.
    a_p = 90;  b_p = 90;  rdy_p = 70;
    start = out_cnt;
    for (int i = 0; i < 400; i++) push_pair({rnd16(), rnd16()}, {rnd16(), rnd16()});
    n = 0;
    while (out_cnt - start < 300 && n < 3000) begin applyStimulus(); n++; end
    if (n >= 3000) failNow("reset_stream_timeout");
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    a_src.delete();  b_src.delete();  exp_q.delete();
    s_a_tvalid = 0;  s_b_tvalid = 0;
    a_acc_prev = 0;  b_acc_prev = 0;  hold_v = 0;  fd_exp = 0;
    col_m = 0;  row_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame with random backpressure, starting from col 0 / row 0.
    clip_seen = 0;
    tl0 = tlast_cnt;
    fd0 = fd_cnt;
    a_p = 90;  b_p = 90;  rdy_p = 75;
    for (int i = 0; i < N * ROWS; i++) push_pair({rnd16(), rnd16()}, {rnd16(), rnd16()});
    drain(60000);
    checkOutput("frame_tlast_count", 32'(tlast_cnt - tl0), ROWS);
    checkOutput("frame_done_count", 32'(fd_cnt - fd0), 1);
    checkOutput("frame_ovf", ovf, clip_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
